keypad_scan_debounce: RTL

//  Scans a 4x4 matrix keypad and debounces the result. Emits a 4-bit key code plus a one-cycle

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_scan_debounce_if.sv | 12 +
 rtl/keypad_row_scanner.sv | 106 ++++++++++
 rtl/keypad_scan_debounce.sv | 134 +++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types: key code map, debounce states, per-scan classification.
// Pure declarations; no latency and no flow control.
package keypad_pkg;

    localparam logic [3:0] ROW_INIT = 4'b1110;

    // Index is raw {row[1:0], col[1:0]}; rows read "1 2 3 A", "4 5 6 B", "7 8 9 C", "E 0 F D".
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_e;

    typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_kind_e;

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Keypad pin and key-event bundle; master is the scanner/debouncer, slave the pins and consumer.
// Plain wires, no latency; key events are unconditional pulses with no backpressure.
interface keypad_scan_debounce_if;
    logic [3:0] columns_i;
    logic [3:0] rows_o;
    logic [3:0] key_o;
    logic       key_valid_o;
    logic       one_shot_o;

    modport master (input columns_i, output rows_o, key_o, key_valid_o, one_shot_o);
    modport slave  (output columns_i, input rows_o, key_o, key_valid_o, one_shot_o);
endinterface

// File: rtl/keypad_row_scanner.sv
// Row drive, column synchronizer and per-scan NONE/SINGLE/MULTI classification with raw index.
// Result strobes once per 4*SCAN_DIV cycles, one cycle after row 3 is sampled; no backpressure.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] columns_i,
    output logic [3:0] rows_o,
    output logic       scan_done_o,
    output scan_kind_e scan_kind_o,
    output logic [3:0] scan_raw_o
);
    localparam int TW = $clog2(SCAN_DIV);

    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    rows_q, rows_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_raw_q, acc_raw_d;
    logic          done_q, done_d;
    scan_kind_e    kind_q, kind_d;
    logic [3:0]    raw_q, raw_d;

    logic          tc;
    logic [3:0]    lows;
    logic [2:0]    pop;
    logic [2:0]    sum;
    logic [1:0]    col_idx;
    logic [1:0]    new_cnt;
    logic [3:0]    new_raw;

    always_comb begin
        tc        = (timer_q == TW'(SCAN_DIV - 1));
        timer_d   = tc ? '0 : timer_q + TW'(1);
        rows_d    = tc ? {rows_q[2:0], rows_q[3]} : rows_q;
        row_idx_d = tc ? row_idx_q + 2'd1 : row_idx_q;

        lows    = ~sync2_q;
        pop     = '0;
        col_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            pop = pop + 3'(lows[i]);
            if (lows[i]) col_idx = 2'(i);
        end

        // Low count saturates at 2: anything beyond one key is just MULTI.
        sum     = 3'(acc_cnt_q) + pop;
        new_cnt = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        new_raw = (pop == 3'd1) ? {row_idx_q, col_idx} : acc_raw_q;

        acc_cnt_d = acc_cnt_q;
        acc_raw_d = acc_raw_q;
        done_d    = 1'b0;
        kind_d    = kind_q;
        raw_d     = raw_q;
        if (tc) begin
            if (row_idx_q == 2'd3) begin
                done_d    = 1'b1;
                kind_d    = (new_cnt == 2'd0) ? SCAN_NONE :
                            (new_cnt == 2'd1) ? SCAN_SINGLE : SCAN_MULTI;
                raw_d     = new_raw;
                acc_cnt_d = '0;
                acc_raw_d = '0;
            end else begin
                acc_cnt_d = new_cnt;
                acc_raw_d = new_raw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            rows_q    <= ROW_INIT;
            row_idx_q <= '0;
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            acc_cnt_q <= '0;
            acc_raw_q <= '0;
            done_q    <= 1'b0;
            kind_q    <= SCAN_NONE;
            raw_q     <= '0;
        end else begin
            timer_q   <= timer_d;
            rows_q    <= rows_d;
            row_idx_q <= row_idx_d;
            sync1_q   <= columns_i;
            sync2_q   <= sync1_q;
            acc_cnt_q <= acc_cnt_d;
            acc_raw_q <= acc_raw_d;
            done_q    <= done_d;
            kind_q    <= kind_d;
            raw_q     <= raw_d;
        end
    end

    assign rows_o      = rows_q;
    assign scan_done_o = done_q;
    assign scan_kind_o = kind_q;
    assign scan_raw_o  = raw_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scan plus press/release debounce emitting key code, held flag and accept pulse.
// Accept lands one cycle after the qualifying scan result; outputs are never stalled.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clk_50MHz_i,
    input  logic                    rst_sync_ha_i,
    keypad_scan_debounce_if.master  kp
);
    localparam int          CW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_SCANS);

    logic [3:0] rows;
    logic       scan_done;
    scan_kind_e scan_kind;
    logic [3:0] scan_raw;

    keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk         (clk_50MHz_i),
        .rst         (rst_sync_ha_i),
        .columns_i   (kp.columns_i),
        .rows_o      (rows),
        .scan_done_o (scan_done),
        .scan_kind_o (scan_kind),
        .scan_raw_o  (scan_raw)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          shot_q, shot_d;

    logic [CW-1:0] cnt_inc;
    logic          accept_en;
    logic [3:0]    accept_raw;
    logic          release_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        key_d      = key_q;
        valid_d    = valid_q;
        shot_d     = 1'b0;
        accept_en  = 1'b0;
        accept_raw = cand_q;
        release_en = 1'b0;
        cnt_inc    = (cnt_q == LIM) ? cnt_q : cnt_q + CW'(1);

        if (scan_done) begin
            unique case (state_q)
                IDLE: if (scan_kind == SCAN_SINGLE) begin
                    cand_d     = scan_raw;
                    cnt_d      = CW'(1);
                    state_d    = PRESS;
                    accept_en  = (LIM == CW'(1));
                    accept_raw = scan_raw;
                end
                PRESS: begin
                    if (scan_kind == SCAN_SINGLE && scan_raw == cand_q) begin
                        cnt_d     = cnt_inc;
                        accept_en = (cnt_inc == LIM);
                    end else if (scan_kind == SCAN_SINGLE) begin
                        cand_d     = scan_raw;
                        cnt_d      = CW'(1);
                        accept_en  = (LIM == CW'(1));
                        accept_raw = scan_raw;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: if (scan_kind == SCAN_NONE) begin
                    cnt_d      = CW'(1);
                    state_d    = RELEASE;
                    release_en = (LIM == CW'(1));
                end
                RELEASE: begin
                    if (scan_kind == SCAN_NONE) begin
                        cnt_d      = cnt_inc;
                        release_en = (cnt_inc == LIM);
                    end else begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (accept_en) begin
            key_d   = KEY_MAP[accept_raw];
            valid_d = 1'b1;
            shot_d  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
        end
        // key_o deliberately keeps the last code after release.
        if (release_en) begin
            valid_d = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_ha_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            shot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            shot_q  <= shot_d;
        end
    end

    assign kp.rows_o      = rows;
    assign kp.key_o       = key_q;
    assign kp.key_valid_o = valid_q;
    assign kp.one_shot_o  = shot_q;

endmodule
